// File: rtl/two_bit_multiplier_if.sv
// two_bit_multiplier_if: operand/product bus of the 2x2 multiplier cell
//   in_valid  - qualifies a and b on the sampling edge
//   a, b      - unsigned 2-bit operands
//   out       - registered 4-bit product
//   out_valid - one-cycle flag marking a new product on out
interface two_bit_multiplier_if;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] out;
    logic       out_valid;
    modport master (output in_valid, a, b, input out, out_valid);
    modport slave (input in_valid, a, b, output out, out_valid);
endinterface

// File: rtl/two_bit_multiplier.sv
// two_bit_multiplier: gate-level unsigned 2x2 multiplier with a registered, valid-flagged product
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - slave side of two_bit_multiplier_if (in_valid, a, b in; out, out_valid out)
module two_bit_multiplier (
    input logic                  clk,
    input logic                  rst,
    two_bit_multiplier_if.slave  bus
);
    logic       p00, p10, p01, p11;
    logic       s1, c1, s2, c2;
    logic [3:0] prod;
    logic [3:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    assign p00  = bus.a[0] & bus.b[0];
    assign p10  = bus.a[1] & bus.b[0];
    assign p01  = bus.a[0] & bus.b[1];
    assign p11  = bus.a[1] & bus.b[1];
    assign s1   = p10 ^ p01;
    assign c1   = p10 & p01;
    // c1 ripples into the second half adder to form bits 2 and 3
    assign s2   = p11 ^ c1;
    assign c2   = p11 & c1;
    assign prod = {c2, s2, s1, p00};
    // The mux select keeps an idle (possibly X) operand bus away from the register
    always_comb begin
        out_d       = bus.in_valid ? prod : out_q;
        out_valid_d = bus.in_valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_two_bit_multiplier.sv
// tb_two_bit_multiplier: directed self-checking bench for two_bit_multiplier
module tb_two_bit_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    two_bit_multiplier_if bus ();
    two_bit_multiplier dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    // Drive inputs on the falling edge, then observe just after the next rising edge
    task automatic step(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input logic [3:0] o, input logic ov);
        chk({tag, "_out"}, bus.out, o);
        chk({tag, "_vld"}, {3'b000, bus.out_valid}, {3'b000, ov});
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.a        = 2'd0;
        bus.b        = 2'd0;
        step(1'b1, 1'b1, 2'd3, 2'd3);
        expect_out("rst1", 4'd0, 1'b0);
        step(1'b1, 1'b1, 2'd3, 2'd3);
        expect_out("rst2", 4'd0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 2'd3);
        expect_out("rst_release", 4'd9, 1'b1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                step(1'b0, 1'b1, 2'(i), 2'(j));
                expect_out($sformatf("sweep_%0dx%0d", i, j), 4'(i * j), 1'b1);
            end
        step(1'b0, 1'b1, 2'd2, 2'd3);
        expect_out("hold_load", 4'd6, 1'b1);
        step(1'b0, 1'b0, 2'd1, 2'd1);
        expect_out("hold_idle1", 4'd6, 1'b0);
        step(1'b0, 1'b0, 2'd1, 2'd1);
        expect_out("hold_idle2", 4'd6, 1'b0);
        step(1'b0, 1'b0, 2'bxx, 2'bxx);
        expect_out("hold_xbus", 4'd6, 1'b0);
        step(1'b0, 1'b1, 2'd3, 2'd2);
        expect_out("b2b_0", 4'd6, 1'b1);
        step(1'b0, 1'b1, 2'd1, 2'd1);
        expect_out("b2b_1", 4'd1, 1'b1);
        step(1'b0, 1'b1, 2'd0, 2'd3);
        expect_out("b2b_2", 4'd0, 1'b1);
        step(1'b0, 1'b1, 2'd3, 2'd3);
        expect_out("b2b_3", 4'd9, 1'b1);
        step(1'b0, 1'b1, 2'd2, 2'd2);
        expect_out("mid_pre", 4'd4, 1'b1);
        step(1'b1, 1'b1, 2'd3, 2'd1);
        expect_out("mid_rst", 4'd0, 1'b0);
        step(1'b0, 1'b0, 2'd3, 2'd1);
        expect_out("mid_after", 4'd0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 2'd2);
        expect_out("carry_0110", 4'b0110, 1'b1);
        step(1'b0, 1'b1, 2'd3, 2'd3);
        expect_out("carry_1001", 4'b1001, 1'b1);
        step(1'b0, 1'b0, 2'd0, 2'd0);
        expect_out("final_idle", 4'b1001, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/two_bit_multiplier.md
Name: two_bit_multiplier

Overview:
- Unsigned 2-bit by 2-bit multiplier producing a 4-bit product.
- Leaf arithmetic cell of the MAC unit's multiplier tree, replicated to build wider multipliers.
- Combinational partial-product and half-adder core, followed by a registered output stage with a valid flag.

Parameters:
- None. All widths are fixed: 2-bit operands, 4-bit product.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies a and b on this clock edge
- a  input  2  unsigned multiplicand
- b  input  2  unsigned multiplier
- out  output  4  unsigned product a*b, registered
- out_valid  output  1  high for one cycle when out holds a new product

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Core is combinational and built from gates, with no `*` operator:
  - partial products: p00 = a[0]&b[0], p10 = a[1]&b[0], p01 = a[0]&b[1], p11 = a[1]&b[1]
  - bit 0 = p00
  - half adder HA1(p10, p01) gives sum s1 and carry c1; bit 1 = s1
  - half adder HA2(p11, c1) gives sum s2 and carry c2; bit 2 = s2, bit 3 = c2
- Core result is always exactly a*b, range 0..9; it cannot overflow 4 bits. Operands are unsigned.
- Register stage, evaluated on each rising edge of clk:
  - rst=1: out <= 4'b0000, out_valid <= 0. Reset takes priority over in_valid.
  - rst=0, in_valid=1: out <= core result of the current a and b; out_valid <= 1.
  - rst=0, in_valid=0: out holds its previous value; out_valid <= 0.
- Latency is exactly 1 cycle, from the edge that samples in_valid=1 to out and out_valid being visible after that edge.
- Throughput is 1 product per cycle. Back-to-back in_valid gives a new out every cycle with out_valid held high.
- No backpressure and no ready signal; a downstream consumer must accept out whenever out_valid=1.
- Reset asserted mid-stream clears out and out_valid on that edge. A request sampled in the same cycle as reset is discarded. The first valid output after reset deasserts appears one cycle after the first in_valid=1 edge.
- Changing a or b while in_valid=0 has no effect on out.
- No X propagation from an idle bus: when in_valid=0, out must not change even if a or b is X.

Test Plan:
- Exhaustive sweep: all 16 (a,b) pairs, one per cycle with in_valid=1 -> out equals a*b one cycle later. Includes 0*x=0, 1*3=3, 2*2=4, 2*3=6, 3*3=9 (4'b1001); out_valid=1 throughout; zero mismatches reported.
- Reset: assert rst for 2 cycles with in_valid=1, a=3, b=3 -> out=0 and out_valid=0 during reset. Deassert rst -> out=9 and out_valid=1 one cycle after the first non-reset sampling edge.
- Hold: a=2, b=3, in_valid=1 for one cycle, then in_valid=0 while a and b change to 1 and 1 -> out=6 and stays 6; out_valid is a 1-cycle pulse.
- Back-to-back: (3,2), (1,1), (0,3), (3,3) on consecutive cycles -> out sequence 6, 1, 0, 9 on consecutive cycles with out_valid continuously high.
- Reset mid-stream: (2,2) sampled, then rst=1 together with in_valid=1 and (3,1) -> out=4 first, then out=0 with out_valid=0; the (3,1) request produces no output.
- Carry chain: a=3, b=2, then a=3, b=3 -> out=4'b0110 (c2=0), then out=4'b1001, which confirms c1 ripples into HA2 and sets c2.
